fifo_rd_ctrl: RTL

Parametrised read-domain controller for the asynchronous FIFO, clocked entirely on `rclk`. It owns the read pointer and the RAM read port. It synchronises the write-domain Gray pointer and generates the read-side status: empty, almost-empty, underflow, level and read count. It adds two features over the previous generation: configurable depth and width, and a selectable first-word-fall-through (FWFT) output mode. It sits between the dual-port FIFO RAM and the read agent's interface.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_ptr_sync.sv | 33 +++
 rtl/fifo_rd_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: Gray/binary conversion,
// default parameters and the output-mode enum.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FWFT        = 0;

    // Widest pointer the converters handle; narrower pointers are zero-extended
    // on the way in and truncated on the way out, which leaves the low bits exact.
    localparam int GRAY_W = 32;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock
// domain; shared by the read- and write-side controllers.
module fifo_ptr_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_ADDR_WIDTH + 1,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             hw_rst_i,
    input  logic             sw_rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge hw_rst_i) begin
        if (hw_rst_i) begin
            sync_q <= '0;
        end else if (sw_rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO, clocked only on rclk.
// Owns the read pointer and RAM read port and produces the read-side status.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = fifo_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = fifo_pkg::DEF_ADDR_WIDTH,
    parameter int SYNC_STAGES = fifo_pkg::DEF_SYNC_STAGES,
    parameter int FWFT        = fifo_pkg::DEF_FWFT
) (
    input  logic                  rclk,
    input  logic                  hw_rst,
    input  logic                  sw_rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int GW = fifo_pkg::GRAY_W;
    localparam fifo_pkg::fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

    logic [PW-1:0]         wgray_s, wbin_s;
    logic [PW-1:0]         rbin_q, rbin_d, rgray_q, rgray_d;
    logic [PW-1:0]         count_q, count_d, level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, empty_q, empty_d;
    logic                  aempty_q, aempty_d, underflow_q, underflow_d;
    // rd_inc: a word leaves the RAM (rbin advances, output register loads).
    // pop_ok: a word is handed to the read agent (counted).
    logic                  rd_inc, pop_ok;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i    (rclk),
        .hw_rst_i (hw_rst),
        .sw_rst_i (sw_rst),
        .d_i      (wptr_gray_async),
        .q_o      (wgray_s)
    );

    assign wbin_s = PW'(fifo_pkg::gray2bin(GW'(wgray_s)));

    // Handshake: read_enable is a request; a word transfers on an edge where
    // read_enable is high and the FIFO is not empty (STD) or read_valid is high (FWFT).
    if (MODE == fifo_pkg::FWFT) begin : g_fwft
        logic [PW-1:0] wbin_vis_q;
        logic          ram_has_word;

        // Prefetch looks one cycle behind the level so the first word lands
        // one edge after its occupancy becomes visible.
        always_ff @(posedge rclk or posedge hw_rst) begin
            if (hw_rst) begin
                wbin_vis_q <= '0;
            end else if (sw_rst) begin
                wbin_vis_q <= '0;
            end else begin
                wbin_vis_q <= wbin_s;
            end
        end

        assign ram_has_word = (wbin_vis_q != rbin_q);
        assign pop_ok       = read_enable && valid_q;
        assign rd_inc       = ram_has_word && (!valid_q || pop_ok);
        assign valid_d      = rd_inc || (valid_q && !pop_ok);
        assign level_d      = wbin_s - rbin_d + PW'(valid_d);
        assign empty_d      = !valid_d;
    end else begin : g_std
        assign pop_ok  = read_enable && !empty_q;
        assign rd_inc  = pop_ok;
        assign valid_d = pop_ok;
        assign level_d = wbin_s - rbin_d;
        assign empty_d = (level_d == '0);
    end

    assign rbin_d      = rbin_q + PW'(rd_inc);
    assign rgray_d     = PW'(fifo_pkg::bin2gray(GW'(rbin_d)));
    assign count_d     = count_q + PW'(pop_ok);
    assign data_d      = rd_inc ? mem_rdata : data_q;
    assign aempty_d    = (level_d <= {1'b0, aempty_value});
    assign underflow_d = read_enable && empty_q;

    always_ff @(posedge rclk or posedge hw_rst) begin
        if (hw_rst) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            count_q     <= '0;
            level_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else if (sw_rst) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            count_q     <= '0;
            level_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            count_q     <= count_d;
            level_q     <= level_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
        end
    end

    assign mem_raddr       = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray       = rgray_q;
    assign read_data       = data_q;
    assign read_valid      = valid_q;
    assign rdempty         = empty_q;
    assign rd_almost_empty = aempty_q;
    assign underflow       = underflow_q;
    assign fifo_read_count = count_q;
    assign rd_level        = level_q;

endmodule
